// File: rtl/spi_rm3100_pkg.sv
// rtl/spi_rm3100_pkg.sv - shared types and constants for the RM3100 SPI responder
package spi_rm3100_pkg;

    // Transaction phases of the responder
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_WR_DATA = 2'd2,
        ST_RD_DATA = 2'd3
    } state_t;

    // Command byte layout: R/W flag on top, 7-bit start address below
    localparam int CMD_READ_BIT = 7;
    localparam int CMD_ADDR_W   = 7;

    // Synchronizer depth for the SPI pins
    localparam int SYNC_STAGES  = 2;

    // RM3100 register map
    localparam logic [6:0] REG_POLL   = 7'h00;
    localparam logic [6:0] REG_CMM    = 7'h01;
    localparam logic [6:0] REG_CCX    = 7'h04;
    localparam logic [6:0] REG_CCY    = 7'h06;
    localparam logic [6:0] REG_CCZ    = 7'h08;
    localparam logic [6:0] REG_TMRC   = 7'h0B;
    localparam logic [6:0] REG_MX     = 7'h24;
    localparam logic [6:0] REG_MY     = 7'h27;
    localparam logic [6:0] REG_MZ     = 7'h2A;
    localparam logic [6:0] REG_BIST   = 7'h33;
    localparam logic [6:0] REG_STATUS = 7'h34;
    localparam logic [6:0] REG_HSHAKE = 7'h35;
    localparam logic [6:0] REG_REVID  = 7'h36;

endpackage

// File: rtl/spi_rm3100_slave_if.sv
// rtl/spi_rm3100_slave_if.sv - SPI pin bundle between RM3100 master and responder
interface spi_rm3100_slave_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs_n, output mosi, input miso);
    modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - pin synchronizer with rise/fall pulse generation
module spi_edge_sync
    import spi_rm3100_pkg::*;
#(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    // Synchronizer stages plus one extra flop holding the previous synced level
    logic [SYNC_STAGES:0] chain_q;
    logic [SYNC_STAGES:0] chain_d;

    // Shift the raw pin into the chain
    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-1:0], din};
    end

    // Chain registers; reset to the pin's idle level so no edge fires out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {(SYNC_STAGES+1){RESET_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sync = chain_q[SYNC_STAGES-1];
    assign rise = chain_q[SYNC_STAGES-1] & ~chain_q[SYNC_STAGES];
    assign fall = ~chain_q[SYNC_STAGES-1] & chain_q[SYNC_STAGES];

endmodule

// File: rtl/spi_rm3100_slave.sv
// rtl/spi_rm3100_slave.sv - SPI mode-3 responder emulating the RM3100 register file
module spi_rm3100_slave
    import spi_rm3100_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    spi_rm3100_slave_if.slave spi,
    output logic              busy,
    output logic              xfer_done,
    output logic              reg_wr,
    output logic [ADDR_W-1:0] reg_waddr,
    output logic [7:0]        reg_wdata,
    input  logic              usr_we,
    input  logic [ADDR_W-1:0] usr_addr,
    input  logic [7:0]        usr_wdata,
    input  logic [ADDR_W-1:0] usr_raddr,
    output logic [7:0]        usr_rdata
);

    localparam int REG_DEPTH = 2**ADDR_W;

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;

    spi_edge_sync #(.RESET_VAL(1'b1)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi.sclk),
        .sync (sclk_sync),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_edge_sync #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi.cs_n),
        .sync (cs_sync),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic                   mosi_sync;

    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [CMD_ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]             tx_q, tx_d;
    logic                   miso_q, miso_d;
    logic                   load_q, load_d;
    logic                   reg_wr_q, reg_wr_d;
    logic                   reg_wen_q, reg_wen_d;
    logic [ADDR_W-1:0]      reg_waddr_q, reg_waddr_d;
    logic [7:0]             reg_wdata_q, reg_wdata_d;
    logic                   busy_q, busy_d;
    logic                   xfer_done_q, xfer_done_d;
    logic [7:0]             usr_rdata_q, usr_rdata_d;
    logic [1:0]             settle_q, settle_d;
    logic                   armed_q, armed_d;
    logic [7:0]             mem_q [REG_DEPTH];

    logic [7:0]             shift_in;
    logic                   addr_in_range;
    logic [7:0]             rd_byte;

    assign mosi_sync     = mosi_q[SYNC_STAGES-1];
    assign shift_in      = {shift_q[6:0], mosi_sync};
    assign addr_in_range = ({1'b0, addr_q} < 8'(REG_DEPTH));
    assign rd_byte       = addr_in_range ? mem_q[addr_q[ADDR_W-1:0]] : 8'h00;

    // Next-state logic for the frame decoder, shifters and user read port
    always_comb begin
        mosi_d      = {mosi_q[SYNC_STAGES-2:0], spi.mosi};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        load_d      = load_q;
        reg_wr_d    = 1'b0;
        reg_wen_d   = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        busy_d      = ~cs_sync;
        xfer_done_d = cs_rise;
        usr_rdata_d = mem_q[usr_raddr];
        settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        // Only arm once the synchronizers have flushed and cs_n is seen idle,
        // so a frame already open at reset is ignored until it closes
        armed_d     = armed_q | ((settle_q == 2'd3) & cs_sync);

        if (cs_rise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
            load_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    // A mode-3 frame must open with sclk at its idle-high level
                    if (cs_fall && armed_q && sclk_sync) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_CMD: begin
                    miso_d = 1'b0;
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = shift_in[CMD_ADDR_W-1:0];
                            if (shift_in[CMD_READ_BIT]) begin
                                state_d = ST_RD_DATA;
                                load_d  = 1'b1;
                            end else begin
                                state_d = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            reg_wr_d    = 1'b1;
                            reg_wen_d   = addr_in_range;
                            reg_waddr_d = addr_q[ADDR_W-1:0];
                            reg_wdata_d = shift_in;
                            addr_d      = addr_q + 1'b1;
                        end
                    end
                end
                ST_RD_DATA: begin
                    // Loading leaves miso alone; bit 7 goes out on the next fall
                    if (load_q) begin
                        tx_d   = rd_byte;
                        load_d = 1'b0;
                    end else if (sclk_fall) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = addr_q + 1'b1;
                            load_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_q      <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            load_q      <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            busy_q      <= 1'b0;
            xfer_done_q <= 1'b0;
            usr_rdata_q <= '0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            mosi_q      <= mosi_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            load_q      <= load_d;
            reg_wr_q    <= reg_wr_d;
            reg_wen_q   <= reg_wen_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            busy_q      <= busy_d;
            xfer_done_q <= xfer_done_d;
            usr_rdata_q <= usr_rdata_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
        end
    end

    // Register file; the SPI write is applied last so it wins an address clash
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            if (usr_we) begin
                mem_q[usr_addr] <= usr_wdata;
            end
            if (reg_wr_q && reg_wen_q) begin
                mem_q[reg_waddr_q] <= reg_wdata_q;
            end
        end
    end

    assign spi.miso  = miso_q;
    assign busy      = busy_q;
    assign xfer_done = xfer_done_q;
    assign reg_wr    = reg_wr_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign usr_rdata = usr_rdata_q;

endmodule

// File: doc/spi_rm3100_slave.md
# spi_rm3100_slave

SPI mode-3 responder that emulates the RM3100 register interface on the sensor side of the bus. It accepts the same framing our RM3100 master produces: a command byte (R/W flag plus 7-bit address) followed by one or more data bytes. The block is used as the loop-back target in system benches and as the sensor stand-in on boards without a magnetometer. It oversamples SCLK, CS_N and MOSI in the system clock domain, holds a local register file, and exposes a user-side port so logic can preload measurement registers.

## Interface
- ADDR_W, 6: register file address width; REG_DEPTH = 2**ADDR_W (64 registers, covering 0x00–0x3F).
- clk  input  1  system clock; all logic is in this domain.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock from the master; idles high (CPOL=1).
- cs_n  input  1  SPI chip select, active low.
- mosi  input  1  serial data from the master.
- miso  output  1  serial data to the master.
- busy  output  1  high while a transaction is open (synced cs_n low).
- xfer_done  output  1  one-cycle pulse when synced cs_n rises.
- reg_wr  output  1  one-cycle pulse per completed SPI write byte.
- reg_waddr  output  ADDR_W  register address of the reg_wr byte.
- reg_wdata  output  8  data of the reg_wr byte.
- usr_we  input  1  user write strobe into the register file.
- usr_addr  input  ADDR_W  user write address.
- usr_wdata  input  8  user write data.
- usr_raddr  input  ADDR_W  user read address.
- usr_rdata  output  8  register contents at usr_raddr, registered with 1-cycle latency.

## Operation
- Input conditioning: sclk, cs_n and mosi each pass through a 2-FF synchronizer. A third flop on sclk and on cs_n gives one-cycle pulses: sclk_rise, sclk_fall, cs_fall, cs_rise.
- Command byte: bit7=1 means read and bit7=0 means write. Bits 6:0 are the start address. Bits are MSB first.
- Mode 3: MOSI is sampled on sclk_rise. MISO changes on sclk_fall.
- FSM states: IDLE, CMD, WR_DATA, RD_DATA.
  - IDLE → CMD on cs_fall. bit_cnt is cleared.
  - CMD shifts 8 bits. On the 8th sclk_rise it latches the address and the R/W flag, then moves to RD_DATA or WR_DATA.
  - In RD_DATA, the byte at the current address is loaded into the TX shift register in the cycle after the 8th rise. Each sclk_fall then drives the next bit, MSB first. After 8 bits the address increments and the next byte is loaded.
  - In WR_DATA, the 8th sclk_rise of each byte pulses reg_wr and writes the register file. The address then increments.
  - Any state → IDLE on cs_rise. A partial byte is discarded: no reg_wr and no register update.
- Address arithmetic is 7-bit and wraps 0x7F→0x00. Addresses ≥ REG_DEPTH read as 0x00, and writes to them are dropped (reg_wr is still pulsed, with reg_waddr = addr[ADDR_W-1:0]).
- If an SPI write and usr_we hit the same address in the same cycle, the SPI write wins.
- A read load and a usr_we to the same address in the same cycle return the old value.
- miso is 0 in IDLE and CMD. The bit 7 of each read byte that is loaded before its falling edge is not driven early: miso stays at its previous value until that sclk_fall.
- Reset values: miso=0, busy=0, xfer_done=0, reg_wr=0, reg_waddr=0, reg_wdata=0, usr_rdata=0, all registers 0x00, FSM IDLE. Reset mid-transfer forces IDLE. The block resynchronises at the next cs_fall and ignores the remainder of the open frame.

## Timing
- Edge pulses fire 3 clk cycles after the pin transition, give or take 1 cycle for sampling phase.
- miso updates 1 cycle after sclk_fall, which is 4 cycles after the pin edge.
- The SCLK half-period must be ≥ 6 clk cycles. Our master uses 8, so it is supported.
- The CS_N setup to the first SCLK edge must be ≥ 4 clk cycles.
- reg_wr fires 1 cycle after the 8th data sclk_rise. The register file holds the new value in the following cycle.
- usr_rdata is registered: address in cycle N, data out in cycle N+1.

## Structure
- spi_rm3100_pkg holds:
  - the FSM state enum;
  - CMD_READ_BIT=7;
  - SYNC_STAGES=2;
  - the RM3100 register address constants (e.g. REVID=0x36, MX=0x24).
- One sub-module, spi_edge_sync: a 2-FF synchronizer plus rise/fall pulse generation. It is instanced for sclk and cs_n. MOSI uses its synchronizer output only.

## Test plan
- Write 0x04 then 0xA5 → one reg_wr with waddr=0x04 and wdata=0xA5; usr_raddr=0x04 then gives usr_rdata=0xA5.
- Preload 0x36=0x22 via usr_we, send read command 0xB6 → master captures 0x22; miso is 0 during the command byte.
- Preload 0x24..0x26 = 0x11, 0x22, 0x33, send 0xA4 with 3 read bytes → 0x11, 0x22, 0x33 in order.
- Send 0x50 then 0x7E (write to out-of-range 0x50), then read 0xD0 → reg_wr pulses, no register changes, and the read returns 0x00.
- Raise cs_n after 5 bits of a write data byte → no reg_wr, busy falls, xfer_done pulses once, FSM is IDLE.
- Assert rst mid-read for 1 cycle → miso=0 and all registers 0x00. The next full transaction completes correctly.
